// File: rtl/pedometer_cmd_driver.sv
// Command driver for the pedometer core: queues weight writes (pairing them into dual
// updates when possible), holds one sample request, and paces countSteps by a fixed window.
module pedometer_cmd_driver #(
  parameter int STEP_CYCLES  = 64,
  parameter int PAIR_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        smp_valid,
  input  logic [7:0]  smp_a,
  input  logic [7:0]  smp_b,
  output logic        smp_ready,
  output logic        countSteps,
  output logic        updateWeights,
  output logic        dualUpdateWeights,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  Addr1,
  output logic [2:0]  Addr2,
  output logic [7:0]  Data1,
  output logic [7:0]  Data2,
  output logic        busy,
  output logic [15:0] steps_issued
);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int TW = $clog2(PAIR_TIMEOUT + 2);

  logic [2:0]    r_fifo_addr [4];
  logic [7:0]    r_fifo_data [4];
  logic [1:0]    r_rd_ptr, r_wr_ptr;
  logic [2:0]    r_count;
  logic          r_held;
  logic [7:0]    r_smp_a, r_smp_b;
  logic [TW-1:0] r_pair_tmr;
  logic [SW-1:0] r_step_cnt;
  logic [15:0]   r_steps;
  logic          r_cs, r_uw, r_du;
  logic [7:0]    r_a, r_b, r_d1, r_d2;
  logic [2:0]    r_a1, r_a2;

  logic       w_push, w_busy, w_tmr_done;
  logic       w_issue_dual, w_issue_single, w_issue_step;
  logic [1:0] w_pop_cnt, w_rd_nxt;
  logic [2:0] w_head_addr, w_next_addr;
  logic [7:0] w_head_data, w_next_data;

  assign wr_ready    = (r_count != 3'd4);
  assign smp_ready   = ~r_held;
  assign w_push      = wr_valid & wr_ready;
  assign w_busy      = (r_step_cnt != {SW{1'b0}});
  assign w_tmr_done  = (r_pair_tmr == TW'(PAIR_TIMEOUT));
  assign w_rd_nxt    = r_rd_ptr + 2'd1;
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_next_addr = r_fifo_addr[w_rd_nxt];
  assign w_next_data = r_fifo_data[w_rd_nxt];

  // Command arbitration: weights always drain before a sample is stepped
  always_comb begin
    w_issue_dual   = 1'b0;
    w_issue_single = 1'b0;
    w_issue_step   = 1'b0;
    w_pop_cnt      = 2'd0;
    if (w_busy) begin
      w_pop_cnt = 2'd0;
    end else if (r_count >= 3'd2) begin
      if (w_head_addr != w_next_addr) begin
        w_issue_dual = 1'b1;
        w_pop_cnt    = 2'd2;
      end else begin
        w_issue_single = 1'b1;
        w_pop_cnt      = 2'd1;
      end
    end else if (r_count == 3'd1) begin
      if (w_tmr_done || r_held) begin
        w_issue_single = 1'b1;
        w_pop_cnt      = 2'd1;
      end else begin
        w_pop_cnt = 2'd0;
      end
    end else begin
      w_issue_step = r_held;
    end
  end

  // Weight FIFO storage and pointers; push and pop may share an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_fifo_addr[i] <= 3'd0;
        r_fifo_data[i] <= 8'd0;
      end
    end else begin
      if (w_push) begin
        r_fifo_addr[r_wr_ptr] <= wr_addr;
        r_fifo_data[r_wr_ptr] <= wr_data;
        r_wr_ptr              <= r_wr_ptr + 2'd1;
      end
      r_rd_ptr <= r_rd_ptr + w_pop_cnt;
      r_count  <= r_count + {2'b00, w_push} - {1'b0, w_pop_cnt};
    end
  end

  // Pair timer, sample holder, step window and step counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pair_tmr <= {TW{1'b0}};
      r_held     <= 1'b0;
      r_smp_a    <= 8'd0;
      r_smp_b    <= 8'd0;
      r_step_cnt <= {SW{1'b0}};
      r_steps    <= 16'd0;
    end else begin
      if (r_count != 3'd1 || w_pop_cnt != 2'd0) begin
        r_pair_tmr <= {TW{1'b0}};
      end else if (!w_tmr_done) begin
        r_pair_tmr <= r_pair_tmr + TW'(1);
      end
      if (w_issue_step) begin
        r_held <= 1'b0;
      end else if (smp_valid && !r_held) begin
        r_held  <= 1'b1;
        r_smp_a <= smp_a;
        r_smp_b <= smp_b;
      end
      if (w_issue_step) begin
        r_step_cnt <= SW'(STEP_CYCLES);
        r_steps    <= r_steps + 16'd1;
      end else if (w_busy) begin
        r_step_cnt <= r_step_cnt - SW'(1);
      end
    end
  end

  // Registered strobes; operands are forced to zero whenever their strobe is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs <= 1'b0;  r_uw <= 1'b0;  r_du <= 1'b0;
      r_a  <= 8'd0;  r_b  <= 8'd0;
      r_a1 <= 3'd0;  r_a2 <= 3'd0;
      r_d1 <= 8'd0;  r_d2 <= 8'd0;
    end else begin
      r_cs <= w_issue_step;
      r_uw <= w_issue_single;
      r_du <= w_issue_dual;
      r_a  <= w_issue_step ? r_smp_a : 8'd0;
      r_b  <= w_issue_step ? r_smp_b : 8'd0;
      r_a1 <= (w_issue_single || w_issue_dual) ? w_head_addr : 3'd0;
      r_d1 <= (w_issue_single || w_issue_dual) ? w_head_data : 8'd0;
      r_a2 <= w_issue_dual ? w_next_addr : 3'd0;
      r_d2 <= w_issue_dual ? w_next_data : 8'd0;
    end
  end

  assign countSteps        = r_cs;
  assign updateWeights     = r_uw;
  assign dualUpdateWeights = r_du;
  assign A                 = r_a;
  assign B                 = r_b;
  assign Addr1             = r_a1;
  assign Addr2             = r_a2;
  assign Data1             = r_d1;
  assign Data2             = r_d2;
  assign busy              = w_busy;
  assign steps_issued      = r_steps;
endmodule

// File: tb/tb_pedometer_cmd_driver.sv
// Randomized + directed bench for pedometer_cmd_driver against a queue-based reference model.
module tb_pedometer_cmd_driver;
  localparam int SC = 8;
  localparam int PT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0, smp_valid = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0, smp_a = 8'd0, smp_b = 8'd0;
  logic        wr_ready, smp_ready, countSteps, updateWeights, dualUpdateWeights, busy;
  logic [7:0]  A, B, Data1, Data2;
  logic [2:0]  Addr1, Addr2;
  logic [15:0] steps_issued;

  pedometer_cmd_driver #(.STEP_CYCLES(SC), .PAIR_TIMEOUT(PT)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .smp_valid(smp_valid), .smp_a(smp_a), .smp_b(smp_b), .smp_ready(smp_ready),
    .countSteps(countSteps), .updateWeights(updateWeights), .dualUpdateWeights(dualUpdateWeights),
    .A(A), .B(B), .Addr1(Addr1), .Addr2(Addr2), .Data1(Data1), .Data2(Data2),
    .busy(busy), .steps_issued(steps_issued)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [10:0] q[$];
  bit          m_held;
  logic [7:0]  m_a, m_b;
  int          m_tmr, m_win;
  logic [15:0] m_steps;
  logic        e_cs, e_uw, e_du;
  logic [7:0]  e_A, e_B, e_d1, e_d2;
  logic [2:0]  e_a1, e_a2;
  int          cyc, n_cs, n_uw, n_du, last_cs_cyc, prev_cs_cyc;

  task automatic model_clear();
    q.delete();
    m_held = 0; m_a = 8'd0; m_b = 8'd0; m_tmr = 0; m_win = 0; m_steps = 16'd0;
    e_cs = 0; e_uw = 0; e_du = 0;
    e_A = 8'd0; e_B = 8'd0; e_d1 = 8'd0; e_d2 = 8'd0; e_a1 = 3'd0; e_a2 = 3'd0;
  endtask

  task automatic model_edge();
    bit do_dual = 0, do_single = 0, do_step = 0;
    int npop = 0;
    bit wr_acc = wr_valid && (q.size() < 4);
    bit smp_acc = smp_valid && !m_held;
    if (m_win == 0) begin
      if (q.size() >= 2) begin
        if (q[0][10:8] != q[1][10:8]) do_dual = 1;
        else do_single = 1;
      end else if (q.size() == 1) begin
        if (m_tmr >= PT || m_held) do_single = 1;
      end else if (m_held) begin
        do_step = 1;
      end
    end
    npop = do_dual ? 2 : (do_single ? 1 : 0);
    e_cs = do_step; e_uw = do_single; e_du = do_dual;
    e_A = do_step ? m_a : 8'd0;
    e_B = do_step ? m_b : 8'd0;
    e_a1 = 3'd0; e_d1 = 8'd0; e_a2 = 3'd0; e_d2 = 8'd0;
    if (npop > 0) begin e_a1 = q[0][10:8]; e_d1 = q[0][7:0]; end
    if (do_dual) begin e_a2 = q[1][10:8]; e_d2 = q[1][7:0]; end
    if (q.size() != 1 || npop > 0) m_tmr = 0;
    else if (m_tmr < PT) m_tmr++;
    repeat (npop) void'(q.pop_front());
    if (wr_acc) q.push_back({wr_addr, wr_data});
    if (do_step) m_held = 0;
    else if (smp_acc) begin m_held = 1; m_a = smp_a; m_b = smp_b; end
    if (do_step) begin m_win = SC; m_steps = m_steps + 16'd1; end
    else if (m_win > 0) m_win--;
  endtask

  task automatic compare();
    check_val("strobes", {countSteps, updateWeights, dualUpdateWeights}, {e_cs, e_uw, e_du});
    check_val("operands", {A, B, Addr1, Addr2, Data1, Data2}, {e_A, e_B, e_a1, e_a2, e_d1, e_d2});
    check_val("busy", busy, m_win != 0);
    check_val("wr_ready", wr_ready, q.size() < 4);
    check_val("smp_ready", smp_ready, !m_held);
    check_val("steps_issued", steps_issued, m_steps);
    n_cs += countSteps; n_uw += updateWeights; n_du += dualUpdateWeights;
    if (countSteps) begin prev_cs_cyc = last_cs_cyc; last_cs_cyc = cyc; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    wr_valid = 0; smp_valid = 0;
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    n_cs = 0; n_uw = 0; n_du = 0;
  endtask

  task automatic apply_reset();
    wr_valid = 0; smp_valid = 0;
    reset = 1;
    #1;
    model_clear();
    compare();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic send_wr(input logic [2:0] a, input logic [7:0] d);
    bit acc = 0;
    int n = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    while (!acc && n < 50) begin acc = wr_ready; tick(); n++; end
    wr_valid = 0;
    if (!acc) check_val("wr_accept_timeout", 0, 1);
  endtask

  task automatic send_smp(input logic [7:0] a, input logic [7:0] b);
    bit acc = 0;
    int n = 0;
    smp_valid = 1; smp_a = a; smp_b = b;
    while (!acc && n < 50) begin acc = smp_ready; tick(); n++; end
    smp_valid = 0;
    if (!acc) check_val("smp_accept_timeout", 0, 1);
  endtask

  task automatic wait_cs();
    int n = 0;
    wr_valid = 0; smp_valid = 0;
    while (!countSteps && n < 40) begin tick(); n++; end
    if (!countSteps) check_val("cs_wait_timeout", 0, 1);
  endtask

  initial begin
    int first;
    logic [4:0] rdy_pat;
    cyc = 0; last_cs_cyc = 0; prev_cs_cyc = 0;
    clr_counts();
    model_clear();
    apply_reset();

    // Differing addresses pair into one dual update
    clr_counts();
    send_wr(3'd1, 8'h11);
    send_wr(3'd2, 8'h22);
    idle(8);
    check_val("dual_count", n_du, 1);
    check_val("dual_no_single", n_uw, 0);

    // Lone write waits PAIR_TIMEOUT before issuing
    send_wr(3'd5, 8'h7F);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (updateWeights && first == 0) first = i;
    end
    check_val("lone_latency", first, PT + 1);

    // Same-address writes stay single and in order
    clr_counts();
    send_wr(3'd3, 8'hA0);
    send_wr(3'd3, 8'hB0);
    idle(10);
    check_val("same_addr_singles", n_uw, 2);
    check_val("same_addr_no_dual", n_du, 0);

    // A held sample flushes the lone write, then steps
    clr_counts();
    send_wr(3'd4, 8'h01);
    send_smp(8'h10, 8'h20);
    idle(3);
    check_val("flush_single", n_uw, 1);
    check_val("flush_step", n_cs, 1);
    check_val("steps_one", steps_issued, 16'd1);
    idle(SC + 2);

    // Back-to-back samples are spaced by the step window; queue fills while busy
    send_smp(8'h01, 8'h02);
    send_smp(8'h03, 8'h04);
    wait_cs();
    check_val("step_spacing", last_cs_cyc - prev_cs_cyc, SC + 1);
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = 3'(i); wr_data = 8'(8'h40 + i);
      rdy_pat[4 - i] = wr_ready;
      tick();
    end
    wr_valid = 0;
    check_val("busy_rdy_pattern", rdy_pat, 5'b11110);
    check_val("no_strobe_busy", n_cs + n_uw + n_du, 0);
    idle(SC + 4);

    // Reset mid-window with entries queued
    send_smp(8'h55, 8'h66);
    wait_cs();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 3'(i); wr_data = 8'(8'h90 + i);
      tick();
    end
    wr_valid = 0;
    #2;
    apply_reset();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_wr_ready", wr_ready, 1'b1);
    clr_counts();
    idle(15);
    check_val("no_stale_cmd", n_cs + n_uw + n_du, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      wr_valid  = ($urandom_range(0, 2) == 0);
      wr_addr   = 3'($urandom_range(0, 3));
      wr_data   = 8'($urandom);
      smp_valid = ($urandom_range(0, 7) == 0);
      smp_a     = 8'($urandom);
      smp_b     = 8'($urandom);
      if ($urandom_range(0, 299) == 0) apply_reset();
      else tick();
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pedometer_cmd_driver.md
# pedometer_cmd_driver

Host-side command driver for the pedometer core's control interface. It accepts weight-write and sample requests from upstream logic over valid/ready handshakes and generates the core's `countSteps`, `updateWeights` and `dualUpdateWeights` strobes with their `A`/`B`, `Addr1`/`Addr2` and `Data1`/`Data2` operands. Where possible it pairs queued weight writes into dual updates. Because the core has no busy output, the block paces `countSteps` by a fixed processing window.

## Interface
Parameters:
- `STEP_CYCLES`, default 64: cycles the core needs after a `countSteps` strobe before it may receive any new command; must be at least 1.
- `PAIR_TIMEOUT`, default 4: cycles a lone queued weight write waits for a partner before it issues as a single update; 0 means issue at once.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: weight-write request valid.
- `wr_addr` in 3: weight address.
- `wr_data` in 8: weight value.
- `wr_ready` out 1: weight queue can accept an entry.
- `smp_valid` in 1: sample request valid.
- `smp_a`, `smp_b` in 8 each: sample operands.
- `smp_ready` out 1: sample holding register is empty.
- `countSteps`, `updateWeights`, `dualUpdateWeights` out 1 each: registered one-cycle command strobes to the core.
- `A`, `B` out 8 each: sample operands; valid only while `countSteps` is high.
- `Addr1`, `Addr2` out 3 each; `Data1`, `Data2` out 8 each: weight operands. Slot 2 is valid only during `dualUpdateWeights`.
- `busy` out 1: a step window is open.
- `steps_issued` out 16: count of `countSteps` strobes; wraps.

## Operation
- **Weight queue:** 4-entry FIFO of {addr, data}.
  - `wr_ready` = !full, computed from registered state only; there is no same-cycle pop bypass.
  - An entry is pushed on a `wr_valid & wr_ready` edge.
- **Sample holder:** one register.
  - `smp_ready` = !held.
  - A held sample is loaded on a `smp_valid & smp_ready` edge.
- **Command decision:** made each cycle the block is not `busy`. At most one strobe per cycle, highest priority first:
  1. Queue count ≥ 2 and the two head addresses differ: issue `dualUpdateWeights` with head in slot 1 and next in slot 2; pop 2.
  2. Queue count ≥ 2 and the two head addresses are equal: issue `updateWeights` with the head only; pop 1. Writes therefore stay in order and the later write wins.
  3. Queue count = 1, and either the pair timer has reached `PAIR_TIMEOUT` or a sample is held: issue `updateWeights` with the head; pop 1.
  4. Queue empty and a sample is held: issue `countSteps` with `A`=smp_a, `B`=smp_b; clear the holder; increment `steps_issued`; open the step window.
- **Pair timer:**
  - Cleared whenever queue count ≠ 1 or a pop occurs.
  - Otherwise increments each cycle and saturates at `PAIR_TIMEOUT`.
- **Ordering:** weights always drain before a sample issues, so a step is computed with every previously accepted weight applied.
- **Step window:**
  - A counter loads `STEP_CYCLES` on the `countSteps` issue edge and decrements to 0.
  - `busy` = counter ≠ 0.
  - While `busy`, no strobes of any kind are issued. Pushes into the queue and a load into the holder are still accepted.
- **Operand outputs:** all are 0 whenever their strobe is low. Operands never hold stale values.
- **Reset:** asynchronous, takes effect immediately. It clears the FIFO, holder, pair timer, step counter, `steps_issued` and all outputs. The only non-zero values at reset are `wr_ready`=1 and `smp_ready`=1. A strobe cut short by reset is not reissued.

## Timing
- A lone write accepted at edge E: `updateWeights` is high during cycle [E+1+PAIR_TIMEOUT, E+2+PAIR_TIMEOUT).
- Two differing-address writes present at edge E: `dualUpdateWeights` is high during cycle [E+1, E+2).
- A sample accepted at edge E with the queue empty and not `busy`: `countSteps` is high during [E+1, E+2).
- Step window: `countSteps` issued at edge S.
  - `busy` is high from edge S through edge S+STEP_CYCLES.
  - The next strobe of any kind is no earlier than edge S+STEP_CYCLES+1.
- Handshake timing:
  - `wr_ready` and `smp_ready` depend only on registered state.
  - Push and pop on the same edge are legal and the FIFO count is net-updated.
  - A full queue stays not-ready in the cycle of a pop and is ready again the cycle after.
  - The holder may load on the same edge it is cleared only from the cycle after; `smp_ready` is low in the issue cycle.
- `steps_issued` updates on the issue edge and wraps from 0xFFFF to 0.

## Test plan
- Reset, then writes (1,0x11) and (2,0x22) on consecutive edges → one `dualUpdateWeights` with Addr1=1, Data1=0x11, Addr2=2, Data2=0x22; no `updateWeights`.
- Single write (5,0x7F), PAIR_TIMEOUT=4, accepted at edge E → `updateWeights` with Addr1=5, Data1=0x7F high exactly in cycle E+5; `Addr2` and `Data2` are 0.
- Writes (3,0xA0), (3,0xB0) → two `updateWeights` in order (0xA0 then 0xB0), never a dual.
- Write (4,0x01) followed by sample A=0x10, B=0x20 on the next edge → `updateWeights` issues without waiting for the timeout; `countSteps` follows with A=0x10, B=0x20; `steps_issued`=1.
- STEP_CYCLES=8: two samples back to back → second `countSteps` exactly 9 edges after the first; 5 writes during `busy` → 4 accepted, `wr_ready` low on the 5th, no strobes during `busy`.
- Assert `reset` in the middle of the step window with 3 entries queued → all outputs 0 immediately, `busy`=0, `wr_ready`=1; after release, no pre-reset command issues.
